rng_apb4_fetch: RTL and testbench

RNG_APB4_FETCH -- requirements
Module: rng_apb4_fetch

---
 rtl/rng_apb4_fetch_pkg.sv | 22 ++
 rtl/rng_fetch_fifo.sv | 59 +++++
 rtl/rng_apb4_fetch.sv | 215 +++++++++++++++++++++
 tb/tb_rng_apb4_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_apb4_fetch_pkg.sv
// Shared definitions for the RNG APB4 fetch engine: register map, CTRL
// enable value and the sequencer state encoding.
package rng_apb4_fetch_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
    localparam logic [31:0] OFF_SEED    = 32'h0000_0004;
    localparam logic [31:0] OFF_VAL     = 32'h0000_0008;
    localparam logic [31:0] CTRL_ENABLE = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_CTRL    = 3'd1,
        ST_WR_SEED    = 3'd2,
        ST_RD_VAL     = 3'd3,
        ST_WAIT_SPACE = 3'd4
    } seq_state_e;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/rng_fetch_fifo.sv
// Power-of-two word buffer between the APB read path and the output stream.
// Push while full is accepted only when a pop happens in the same cycle.
module rng_fetch_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [31:0]                push_data_i,
    input  logic                       pop_i,
    output logic [31:0]                data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign empty_o = (r_count == {CW{1'b0}});
    assign full_o  = (r_count == CW'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign count_o = r_count;
    assign data_o  = empty_o ? 32'h0000_0000 : r_mem[r_rd_ptr];

    // storage, pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rng_apb4_fetch.sv
// APB4 initiator that enables an RNG, loads a seed and streams VAL reads into
// a FIFO. Define RNG_FETCH_TIMEOUT_EN to abort ACCESS phases after TIMEOUT_CYC cycles.
module rng_apb4_fetch
    import rng_apb4_fetch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [31:0] seed_i,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] L_DEPTH = CW'(FIFO_DEPTH);

    seq_state_e    r_state, w_state_nx;
    logic          r_psel, w_psel_nx;
    logic          r_penable, w_penable_nx;
    logic          r_pwrite, w_pwrite_nx;
    logic [31:0]   r_paddr, w_paddr_nx;
    logic [31:0]   r_pwdata, w_pwdata_nx;
    logic [31:0]   r_seed, w_seed_nx;
    logic          r_err, w_err_nx;
    logic          r_busy;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_fifo_data;
    logic          w_complete;
    logic          w_push;
    logic          w_pop;
    logic          w_full_next;
    logic          w_timeout;

    assign w_complete  = r_psel && r_penable && pready_i;
    assign w_push      = w_complete && (r_state == ST_RD_VAL) && !pslverr_i;
    assign w_pop       = !w_empty && ready_i;
    // occupancy after this edge decides whether the next read may start
    assign w_full_next = (w_full && !w_pop) ||
                         ((w_count == (L_DEPTH - CW'(1))) && w_push && !w_pop);

`ifdef RNG_FETCH_TIMEOUT_EN
    logic [31:0] r_wait_cnt;

    assign w_timeout = r_psel && r_penable && !pready_i &&
                       (r_wait_cnt == 32'(TIMEOUT_CYC - 1));

    // counts consecutive ACCESS cycles without pready_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt <= 32'd0;
        end else if (r_psel && r_penable && !pready_i) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
        end else begin
            r_wait_cnt <= 32'd0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

    // sequencer next state and next APB drive values
    always_comb begin
        w_state_nx   = r_state;
        w_psel_nx    = r_psel;
        w_penable_nx = r_penable;
        w_pwrite_nx  = r_pwrite;
        w_paddr_nx   = r_paddr;
        w_pwdata_nx  = r_pwdata;
        w_seed_nx    = r_seed;
        w_err_nx     = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nx   = ST_WR_CTRL;
                    w_psel_nx    = 1'b1;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b1;
                    w_paddr_nx   = reg_addr(BASE_ADDR, OFF_CTRL);
                    w_pwdata_nx  = CTRL_ENABLE;
                    w_seed_nx    = seed_i;
                    w_err_nx     = 1'b0;
                end else begin
                    w_psel_nx    = 1'b0;
                    w_penable_nx = 1'b0;
                end
            end
            ST_WR_CTRL, ST_WR_SEED, ST_RD_VAL: begin
                if (!r_penable) begin
                    w_penable_nx = 1'b1;
                end else if (w_timeout || (pready_i && pslverr_i)) begin
                    w_state_nx   = ST_IDLE;
                    w_psel_nx    = 1'b0;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b0;
                    w_err_nx     = 1'b1;
                end else if (!pready_i) begin
                    w_penable_nx = 1'b1;
                end else if (stop_i) begin
                    w_state_nx   = ST_IDLE;
                    w_psel_nx    = 1'b0;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b0;
                end else if (r_state == ST_WR_CTRL) begin
                    w_state_nx   = ST_WR_SEED;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b1;
                    w_paddr_nx   = reg_addr(BASE_ADDR, OFF_SEED);
                    w_pwdata_nx  = r_seed;
                end else if (w_full_next) begin
                    w_state_nx   = ST_WAIT_SPACE;
                    w_psel_nx    = 1'b0;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b0;
                end else begin
                    w_state_nx   = ST_RD_VAL;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b0;
                    w_paddr_nx   = reg_addr(BASE_ADDR, OFF_VAL);
                    w_pwdata_nx  = 32'h0000_0000;
                end
            end
            ST_WAIT_SPACE: begin
                if (stop_i) begin
                    w_state_nx   = ST_IDLE;
                end else if (!w_full_next) begin
                    w_state_nx   = ST_RD_VAL;
                    w_psel_nx    = 1'b1;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b0;
                    w_paddr_nx   = reg_addr(BASE_ADDR, OFF_VAL);
                    w_pwdata_nx  = 32'h0000_0000;
                end else begin
                    w_psel_nx    = 1'b0;
                end
            end
            default: begin
                w_state_nx   = ST_IDLE;
                w_psel_nx    = 1'b0;
                w_penable_nx = 1'b0;
                w_pwrite_nx  = 1'b0;
            end
        endcase
    end

    // sequencer and APB output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'h0000_0000;
            r_pwdata  <= 32'h0000_0000;
            r_seed    <= 32'h0000_0000;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_psel    <= w_psel_nx;
            r_penable <= w_penable_nx;
            r_pwrite  <= w_pwrite_nx;
            r_paddr   <= w_paddr_nx;
            r_pwdata  <= w_pwdata_nx;
            r_seed    <= w_seed_nx;
            r_err     <= w_err_nx;
            r_busy    <= (w_state_nx != ST_IDLE);
        end
    end

    rng_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (prdata_i),
        .pop_i       (w_pop),
        .data_o      (w_fifo_data),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign paddr_o   = r_paddr;
    assign psel_o    = r_psel;
    assign penable_o = r_penable;
    assign pwrite_o  = r_pwrite;
    assign pwdata_o  = r_pwdata;
    assign data_o    = w_fifo_data;
    assign valid_o   = !w_empty;
    assign busy_o    = r_busy;
    assign err_o     = r_err;

endmodule

// File: tb/tb_rng_apb4_fetch.sv
// Directed bench for rng_apb4_fetch: bench-side APB responder, stream consumer
// and a queue scoreboard of words expected on data_o.
module tb_rng_apb4_fetch;

    logic        clk = 1'b0;
    logic        rst_i, start_i, stop_i, pready_i, pslverr_i, ready_i;
    logic [31:0] seed_i, prdata_i;
    logic [31:0] paddr_o, pwdata_o, data_o;
    logic        psel_o, penable_o, pwrite_o, valid_o, busy_o, err_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    int          n_rd = 0, sess_rd = 0, err_at = 0, acc_cnt = 0;
    int          resp_wait = 0, wait_cnt = 0;
    logic        resp_hold = 1'b0, cons_rdy = 1'b0, lat_chk = 1'b0, lat_pend = 1'b0;
    logic [31:0] lat_word = 32'd0, s_addr = 32'd0, s_wdata = 32'd0;
    logic        s_wr = 1'b0;
    int          r0, acc0;

    rng_apb4_fetch dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .seed_i    (seed_i),
        .paddr_o   (paddr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pready_i  (pready_i),
        .prdata_i  (prdata_i),
        .pslverr_i (pslverr_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_word(input int idx);
        logic [31:0] v;
        v = 32'(idx) * 32'h9E37_79B9;
        return v ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one cycle: sample at the falling edge, then drive consumer and responder
    task automatic tick();
        logic [31:0] w;
        @(negedge clk);
        if (lat_pend) begin
            check("lat_valid", 32'(valid_o), 32'd1);
            check("lat_data", data_o, lat_word);
            lat_pend = 1'b0;
        end
        ready_i = cons_rdy;
        if (valid_o && ready_i) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL sb_underflow: observed word %h, expected no word", data_o);
            end
            if (exp_q.size() > 0) check("sb_data", data_o, exp_q.pop_front());
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 32'd0;
        if (psel_o && !penable_o) begin
            s_addr  = paddr_o;
            s_wr    = pwrite_o;
            s_wdata = pwdata_o;
        end
        if (psel_o && penable_o) begin
            acc_cnt++;
            check("stable_addr", paddr_o, s_addr);
            check("stable_write", 32'(pwrite_o), 32'(s_wr));
            check("stable_wdata", pwdata_o, s_wdata);
            if (!resp_hold) begin
                if (wait_cnt < resp_wait) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    pready_i = 1'b1;
                    if (!pwrite_o) begin
                        n_rd++;
                        sess_rd++;
                        w = mk_word(n_rd);
                        prdata_i = w;
                        if (sess_rd == err_at) begin
                            pslverr_i = 1'b1;
                        end else begin
                            exp_q.push_back(w);
                            lat_word = w;
                            lat_pend = lat_chk;
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy_o) break;
        end
        check("wait_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic start_session(input logic [31:0] seed);
        sess_rd = 0;
        seed_i  = seed;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; seed_i = 32'd0;
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'd0; ready_i = 1'b0;

        // reset values
        repeat (3) tick();
        check("rst_psel", 32'(psel_o), 32'd0);
        check("rst_penable", 32'(penable_o), 32'd0);
        check("rst_pwrite", 32'(pwrite_o), 32'd0);
        check("rst_paddr", paddr_o, 32'd0);
        check("rst_pwdata", pwdata_o, 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        tick();
        check("idle_psel", 32'(psel_o), 32'd0);

        // configure sequence and zero-wait back-to-back reads
        cons_rdy = 1'b1;
        lat_chk  = 1'b1;
        start_session(32'hDEAD_BEEF);
        check("ctrl_setup_psel", 32'(psel_o), 32'd1);
        check("ctrl_setup_pen", 32'(penable_o), 32'd0);
        check("ctrl_addr", paddr_o, 32'h0000_0000);
        check("ctrl_write", 32'(pwrite_o), 32'd1);
        check("ctrl_wdata", pwdata_o, 32'h0000_0001);
        check("busy_on", 32'(busy_o), 32'd1);
        tick();
        check("ctrl_access_pen", 32'(penable_o), 32'd1);
        tick();
        check("seed_setup_pen", 32'(penable_o), 32'd0);
        check("seed_addr", paddr_o, 32'h0000_0004);
        check("seed_write", 32'(pwrite_o), 32'd1);
        check("seed_wdata", pwdata_o, 32'hDEAD_BEEF);
        tick();
        tick();
        check("val_setup_psel", 32'(psel_o), 32'd1);
        check("val_setup_pen", 32'(penable_o), 32'd0);
        check("val_addr", paddr_o, 32'h0000_0008);
        check("val_write", 32'(pwrite_o), 32'd0);
        r0 = n_rd;
        repeat (20) tick();
        check("throughput", 32'(n_rd - r0), 32'd10);
        lat_chk = 1'b0;
        stop_i  = 1'b1;
        wait_idle(10);
        stop_i  = 1'b0;
        check("stop_psel", 32'(psel_o), 32'd0);
        repeat (3) tick();
        check("drain1_q", 32'(exp_q.size()), 32'd0);
        check("drain1_valid", 32'(valid_o), 32'd0);

        // back-pressure: FIFO fills, one pop releases exactly one read
        cons_rdy = 1'b0;
        r0 = n_rd;
        start_session(32'h0123_4567);
        repeat (40) tick();
        check("full_reads", 32'(n_rd - r0), 32'd4);
        check("full_psel", 32'(psel_o), 32'd0);
        check("full_busy", 32'(busy_o), 32'd1);
        check("full_valid", 32'(valid_o), 32'd1);
        cons_rdy = 1'b1;
        tick();
        cons_rdy = 1'b0;
        repeat (20) tick();
        check("one_more_read", 32'(n_rd - r0), 32'd5);
        check("refull_psel", 32'(psel_o), 32'd0);
        stop_i = 1'b1;
        wait_idle(5);
        stop_i = 1'b0;
        check("stop_keeps_words", 32'(valid_o), 32'd1);
        cons_rdy = 1'b1;
        repeat (8) tick();
        check("drain2_q", 32'(exp_q.size()), 32'd0);
        check("drain2_valid", 32'(valid_o), 32'd0);

        // slave error on the third read
        resp_wait = 1;
        err_at    = 3;
        start_session(32'hCAFE_F00D);
        wait_idle(60);
        check("slverr_err", 32'(err_o), 32'd1);
        check("slverr_psel", 32'(psel_o), 32'd0);
        check("slverr_reads", 32'(sess_rd), 32'd3);
        repeat (4) tick();
        check("slverr_q", 32'(exp_q.size()), 32'd0);
        check("slverr_valid", 32'(valid_o), 32'd0);
        check("err_sticky", 32'(err_o), 32'd1);
        err_at = 0;
        start_session(32'h1111_2222);
        check("err_clear", 32'(err_o), 32'd0);
        check("restart_busy", 32'(busy_o), 32'd1);
        stop_i = 1'b1;
        wait_idle(20);
        stop_i = 1'b0;
        resp_wait = 0;
        repeat (4) tick();

        // responder never ready
        resp_hold = 1'b1;
        acc0 = acc_cnt;
        start_session(32'h3333_4444);
        repeat (300) tick();
`ifdef RNG_FETCH_TIMEOUT_EN
        check("to_psel", 32'(psel_o), 32'd0);
        check("to_penable", 32'(penable_o), 32'd0);
        check("to_err", 32'(err_o), 32'd1);
        check("to_busy", 32'(busy_o), 32'd0);
        check("to_access_cycles", 32'(acc_cnt - acc0), 32'd255);
`else
        check("hang_psel", 32'(psel_o), 32'd1);
        check("hang_penable", 32'(penable_o), 32'd1);
        check("hang_busy", 32'(busy_o), 32'd1);
`endif
        resp_hold = 1'b0;
        stop_i = 1'b1;
        wait_idle(10);
        stop_i = 1'b0;
        repeat (4) tick();

        // asynchronous reset during ACCESS with buffered words
        cons_rdy = 1'b0;
        start_session(32'h5555_6666);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sess_rd >= 2) break;
        end
        check("pre_rst_reads", 32'(sess_rd), 32'd2);
        resp_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (psel_o && penable_o) break;
        end
        check("pre_rst_access", 32'(penable_o), 32'd1);
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("arst_psel", 32'(psel_o), 32'd0);
        check("arst_penable", 32'(penable_o), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_data", data_o, 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_paddr", paddr_o, 32'd0);
        exp_q.delete();
        resp_hold = 1'b0;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (3) tick();
        check("post_rst_psel", 32'(psel_o), 32'd0);
        check("post_rst_valid", 32'(valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
